// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Main control state machine of the multicycle CPU. Steps each instruction
//   through fetch, decode, execute, memory and writeback (one state per clock)
//   and drives every datapath enable, including the instruction register load.
//
// Memory handshake: the FSM holds a memory request (MemRead or MemWrite with
//   its address source) steady for as long as it sits in FETCH, MEM_RD or
//   MEM_WR. mem_ready=1 in a cycle means the access completes in that cycle,
//   and the FSM leaves the state on the following clock edge. The FSM never
//   withdraws a request before mem_ready is seen.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   OPcode            latched opcode from the decoder, valid from DECODE on
//   zero              ALU zero flag (consumed by the PC write logic)
//   mem_ready         memory access completes this cycle
//   IRWrite..PCSource datapath enables and mux selects
//   state             current state, for debug
//   illegal           one-cycle pulse when DECODE sees an undefined opcode
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int OPW  = 6,
    parameter int ALUW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  OPcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            BranchNe,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            RegDst,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [ALUW-1:0] ALUOp,
    output logic [1:0]      PCSource,
    output logic [3:0]      state,
    output logic            illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [OPW-1:0]  OP_LW   = OPW'(6'b100000);
    localparam logic [OPW-1:0]  OP_SW   = OPW'(6'b100001);
    localparam logic [OPW-1:0]  OP_BEQ  = OPW'(6'b100010);
    localparam logic [OPW-1:0]  OP_BNE  = OPW'(6'b100011);
    localparam logic [OPW-1:0]  OP_J    = OPW'(6'b100100);
    localparam logic [OPW-1:0]  OP_HALT = OPW'(6'b111111);
    localparam logic [ALUW-1:0] ALU_ADD = '0;
    localparam logic [ALUW-1:0] ALU_SUB = ALUW'(1);

    state_t cur_state, nxt_state;

    logic is_r, is_i;

    // The two top opcode bits select the ALU classes.
    assign is_r  = (OPcode[OPW-1:OPW-2] == 2'b00);
    assign is_i  = (OPcode[OPW-1:OPW-2] == 2'b01);
    assign state = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state   = cur_state;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        PCSource    = 2'b00;
        illegal     = 1'b0;

        unique case (cur_state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;            // PC + 4
                if (mem_ready) begin
                    // Qualified by rst_n so reset held with mem_ready=1
                    // can never load IR or PC.
                    IRWrite   = rst_n;
                    PCWrite   = rst_n;
                    nxt_state = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;            // PC + (imm << 2): branch target
                if (is_r)                              nxt_state = EXEC_R;
                else if (is_i)                         nxt_state = EXEC_I;
                else if (OPcode == OP_LW || OPcode == OP_SW)   nxt_state = MEM_ADDR;
                else if (OPcode == OP_BEQ || OPcode == OP_BNE) nxt_state = BRANCH;
                else if (OPcode == OP_J)               nxt_state = JUMP;
                else if (OPcode == OP_HALT)            nxt_state = HALT;
                else begin
                    illegal   = 1'b1;
                    nxt_state = FETCH;
                end
            end
            EXEC_R: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b00;
                ALUOp     = OPcode[ALUW-1:0];
                nxt_state = WB_ALU;
            end
            EXEC_I: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp     = OPcode[ALUW-1:0];
                nxt_state = WB_ALU;
            end
            WB_ALU: begin
                RegWrite  = 1'b1;
                RegDst    = is_r;
                nxt_state = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = (OPcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) nxt_state = MEM_WB;
            end
            MEM_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                nxt_state = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;            // held through the whole stall
                IorD     = 1'b1;
                if (mem_ready) nxt_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b00;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = OPcode[0];
                nxt_state   = FETCH;
            end
            JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                nxt_state = FETCH;
            end
            HALT: begin
                nxt_state = HALT;
            end
            default: begin
                nxt_state = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Directed bench for the multicycle control FSM. Inputs change on the
//   falling edge; outputs are sampled 1 ns later, well away from the rising
//   edge. Expected state sequences are queued in exp_q per scenario.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] OPcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       IRWrite, PCWrite, PCWriteCond, BranchNe, IorD, MemRead;
    logic       MemWrite, MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp, state;
    logic       illegal;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_s;

    multicycle_control_fsm #(.OPW(6), .ALUW(4)) dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .zero(zero),
        .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state(state), .illegal(illegal)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (MemRead !== 1'b1) begin bad++; $display("FAIL reset_memread got=%b want=1", MemRead); end
        total++; if (ALUSrcB !== 2'b01 || ALUOp !== 4'h0 || IorD !== 1'b0 || ALUSrcA !== 1'b0) begin
            bad++; $display("FAIL reset_alu srcb=%b op=%h iord=%b srca=%b want 01/0/0/0", ALUSrcB, ALUOp, IorD, ALUSrcA); end
        total++; if ({IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite, illegal} !== 6'b0) begin
            bad++; $display("FAIL reset_enables got=%b want=000000", {IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite, illegal}); end
        mem_ready = 1'b1; #1;
        total++; if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
            bad++; $display("FAIL reset_ready_writes irw=%b pcw=%b want 0/0", IRWrite, PCWrite); end
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_r_type();
        bit mr[5] = '{1, 1, 1, 1, 0};
        OPcode = 6'b000010;
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = mr[i]; #1;
            exp_s = exp_q.pop_front();
            total++; if (state !== exp_s) begin bad++; $display("FAIL r_state[%0d] got=%0d want=%0d", i, state, exp_s); end
            if (i == 0) begin
                total++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || PCSource !== 2'b00) begin
                    bad++; $display("FAIL r_fetch irw=%b pcw=%b pcsrc=%b want 1/1/00", IRWrite, PCWrite, PCSource); end
            end
            if (i == 1) begin
                total++; if (ALUSrcB !== 2'b11 || ALUSrcA !== 1'b0 || ALUOp !== 4'h0) begin
                    bad++; $display("FAIL r_decode srcb=%b srca=%b op=%h want 11/0/0", ALUSrcB, ALUSrcA, ALUOp); end
            end
            if (i == 2) begin
                total++; if (ALUOp !== 4'b0010 || ALUSrcB !== 2'b00 || ALUSrcA !== 1'b1) begin
                    bad++; $display("FAIL r_exec op=%b srcb=%b srca=%b want 0010/00/1", ALUOp, ALUSrcB, ALUSrcA); end
            end
            if (i == 3) begin
                total++; if (RegWrite !== 1'b1 || RegDst !== 1'b1 || MemtoReg !== 1'b0) begin
                    bad++; $display("FAIL r_wb regw=%b regdst=%b m2r=%b want 1/1/0", RegWrite, RegDst, MemtoReg); end
            end
            if (i == 4) begin
                total++; if (IRWrite !== 1'b0 || MemRead !== 1'b1) begin
                    bad++; $display("FAIL r_fetch_stall irw=%b memrd=%b want 0/1", IRWrite, MemRead); end
            end
        end
    endtask

    task automatic test_i_type();
        OPcode = 6'b010101;
        exp_q = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = (i != 4); #1;
            exp_s = exp_q.pop_front();
            total++; if (state !== exp_s) begin bad++; $display("FAIL i_state[%0d] got=%0d want=%0d", i, state, exp_s); end
            if (i == 2) begin
                total++; if (ALUOp !== 4'b0101 || ALUSrcB !== 2'b10 || ALUSrcA !== 1'b1) begin
                    bad++; $display("FAIL i_exec op=%b srcb=%b srca=%b want 0101/10/1", ALUOp, ALUSrcB, ALUSrcA); end
            end
            if (i == 3) begin
                total++; if (RegWrite !== 1'b1 || RegDst !== 1'b0) begin
                    bad++; $display("FAIL i_wb regw=%b regdst=%b want 1/0", RegWrite, RegDst); end
            end
        end
    endtask

    task automatic test_lw_stall();
        bit mr[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
        OPcode = 6'b100000;
        exp_q = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); mem_ready = mr[i]; #1;
            exp_s = exp_q.pop_front();
            total++; if (state !== exp_s) begin bad++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, state, exp_s); end
            total++; if ((int'(IRWrite) + int'(MemWrite) + int'(RegWrite)) > 1) begin
                bad++; $display("FAIL lw_onehot[%0d] got irw=%b memw=%b regw=%b want at most one", i, IRWrite, MemWrite, RegWrite); end
            if (i == 2) begin
                total++; if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || ALUOp !== 4'h0) begin
                    bad++; $display("FAIL lw_addr srca=%b srcb=%b op=%h want 1/10/0", ALUSrcA, ALUSrcB, ALUOp); end
            end
            if (i >= 3 && i <= 6) begin
                total++; if (MemRead !== 1'b1 || IorD !== 1'b1 || RegWrite !== 1'b0) begin
                    bad++; $display("FAIL lw_memrd[%0d] memrd=%b iord=%b regw=%b want 1/1/0", i, MemRead, IorD, RegWrite); end
            end
            if (i == 7) begin
                total++; if (RegWrite !== 1'b1 || MemtoReg !== 1'b1 || RegDst !== 1'b0) begin
                    bad++; $display("FAIL lw_wb regw=%b m2r=%b regdst=%b want 1/1/0", RegWrite, MemtoReg, RegDst); end
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops[2] = '{6'b100011, 6'b100010};
        for (int k = 0; k < 2; k++) begin
            OPcode = ops[k];
            exp_q = '{4'd0, 4'd1, 4'd9, 4'd0};
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); mem_ready = (i != 3); #1;
                exp_s = exp_q.pop_front();
                total++; if (state !== exp_s) begin bad++; $display("FAIL br%0d_state[%0d] got=%0d want=%0d", k, i, state, exp_s); end
                if (i == 2) begin
                    total++; if (PCWriteCond !== 1'b1 || PCSource !== 2'b01 || ALUOp !== 4'b0001 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
                        bad++; $display("FAIL br%0d_ctl pcwc=%b pcsrc=%b op=%b srca=%b srcb=%b want 1/01/0001/1/00", k, PCWriteCond, PCSource, ALUOp, ALUSrcA, ALUSrcB); end
                    total++; if (BranchNe !== (k == 0)) begin
                        bad++; $display("FAIL br%0d_ne got=%b want=%b", k, BranchNe, (k == 0)); end
                end
            end
        end
    endtask

    task automatic test_jump();
        OPcode = 6'b100100;
        exp_q = '{4'd0, 4'd1, 4'd10, 4'd0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = (i != 3); #1;
            exp_s = exp_q.pop_front();
            total++; if (state !== exp_s) begin bad++; $display("FAIL j_state[%0d] got=%0d want=%0d", i, state, exp_s); end
            if (i == 2) begin
                total++; if (PCWrite !== 1'b1 || PCSource !== 2'b10 || PCWriteCond !== 1'b0) begin
                    bad++; $display("FAIL j_ctl pcw=%b pcsrc=%b pcwc=%b want 1/10/0", PCWrite, PCSource, PCWriteCond); end
            end
        end
    endtask

    task automatic test_illegal();
        OPcode = 6'b101111;
        exp_q = '{4'd0, 4'd1, 4'd0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ready = (i == 0); #1;
            exp_s = exp_q.pop_front();
            total++; if (state !== exp_s) begin bad++; $display("FAIL ill_state[%0d] got=%0d want=%0d", i, state, exp_s); end
            if (i >= 1) begin
                total++; if (illegal !== (i == 1)) begin
                    bad++; $display("FAIL ill_pulse[%0d] got=%b want=%b", i, illegal, (i == 1)); end
                total++; if ({IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite} !== 5'b0) begin
                    bad++; $display("FAIL ill_enables[%0d] got=%b want=00000", i, {IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite}); end
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        bit mr[5] = '{1, 1, 1, 0, 0};
        OPcode = 6'b100001;
        exp_q = '{4'd0, 4'd1, 4'd5, 4'd8, 4'd8};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = mr[i]; #1;
            exp_s = exp_q.pop_front();
            total++; if (state !== exp_s) begin bad++; $display("FAIL sw_state[%0d] got=%0d want=%0d", i, state, exp_s); end
            if (i >= 3) begin
                total++; if (MemWrite !== 1'b1 || IorD !== 1'b1 || MemRead !== 1'b0) begin
                    bad++; $display("FAIL sw_memwr[%0d] memw=%b iord=%b memrd=%b want 1/1/0", i, MemWrite, IorD, MemRead); end
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL sw_async_state got=%0d want=0", state); end
        total++; if (MemWrite !== 1'b0 || MemRead !== 1'b1) begin
            bad++; $display("FAIL sw_async_mem memw=%b memrd=%b want 0/1", MemWrite, MemRead); end
        mem_ready = 1'b1; #1;
        total++; if ({IRWrite, PCWrite, RegWrite, MemWrite} !== 4'b0) begin
            bad++; $display("FAIL sw_async_enables got=%b want=0000", {IRWrite, PCWrite, RegWrite, MemWrite}); end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_halt();
        OPcode = 6'b111111;
        exp_q = '{4'd0, 4'd1, 4'd11};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ready = (i == 0); #1;
            exp_s = exp_q.pop_front();
            total++; if (state !== exp_s) begin bad++; $display("FAIL halt_state[%0d] got=%0d want=%0d", i, state, exp_s); end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); mem_ready = 1'($urandom_range(0, 1)); #1;
            total++; if (state !== 4'd11) begin bad++; $display("FAIL halt_hold[%0d] got=%0d want=11", i, state); end
            total++; if ({IRWrite, PCWrite, PCWriteCond, MemRead, MemWrite, RegWrite, illegal} !== 7'b0) begin
                bad++; $display("FAIL halt_enables[%0d] got=%b want=0000000", i, {IRWrite, PCWrite, PCWriteCond, MemRead, MemWrite, RegWrite, illegal}); end
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL halt_reset got=%0d want=0", state); end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL halt_after_reset got=%0d want=0", state); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_lw_stall();
        test_branch();
        test_jump();
        test_illegal();
        test_reset_mid_sw();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
